// File: rtl/fft_pkg.sv
// Shared definitions for the FFT sequencing, butterfly and twiddle-address blocks.
// Holds the default transform size, the sequencer state encoding and the index width.
package fft_pkg;

  localparam int FFT_SIZE_DEF = 64;
  localparam int FFT_LOG2_DEF = 6;
  localparam int IDX_W        = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } fft_state_e;

endpackage

// File: rtl/fft_butterfly_seq_if.sv
// Control and index-issue bundle between the butterfly sequencer and its downstream stage.
// The sequencer drives the index set through the master modport.
interface fft_butterfly_seq_if;
  import fft_pkg::*;

  logic             start;
  logic             bf_ready;
  logic             bf_retire;
  logic [IDX_W-1:0] n;
  logic [IDX_W-1:0] p;
  logic [IDX_W-1:0] counter;
  logic             bf_valid;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    input  start, bf_ready, bf_retire,
    output n, p, counter, bf_valid, busy, done, err
  );

  modport slave (
    output start, bf_ready, bf_retire,
    input  n, p, counter, bf_valid, busy, done, err
  );

endinterface

// File: rtl/fft_idx_counter.sv
// Nested group/twiddle counters for one FFT pass: k runs 0..span-1 inside each group g.
// wrap flags the last k of a group, last flags the final group of the pass.
module fft_idx_counter
  import fft_pkg::*;
#(
  parameter  int SIZE      = FFT_SIZE_DEF,
  parameter  int LOG2_SIZE = FFT_LOG2_DEF,
  localparam int CW        = LOG2_SIZE + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  input  logic [CW-1:0] span,
  output logic [CW-1:0] g,
  output logic [CW-1:0] k,
  output logic          wrap,
  output logic          last
);

  logic [CW-1:0] grp_end;

  // Group g covers indices up to (g+1)*2*span; the pass ends when that reaches SIZE.
  assign grp_end = (g + CW'(1)) * (span << 1);
  assign wrap    = (k == span - CW'(1));
  assign last    = (grp_end == CW'(SIZE));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      g <= '0;
      k <= '0;
    end else if (adv) begin
      if (wrap) begin
        k <= '0;
        g <= last ? '0 : g + CW'(1);
      end else begin
        k <= k + CW'(1);
      end
    end
  end

endmodule

// File: rtl/fft_butterfly_seq.sv
// Radix-2 FFT butterfly sequencer: issues (n, p, counter) per pass with a valid/ready
// handshake and holds a barrier between passes until every issued butterfly has retired.
module fft_butterfly_seq
  import fft_pkg::*;
#(
  parameter int SIZE      = FFT_SIZE_DEF,
  parameter int LOG2_SIZE = FFT_LOG2_DEF
) (
  input logic                 clk,
  input logic                 rst,
  fft_butterfly_seq_if.master bus
);

  localparam int CW = LOG2_SIZE + 1;

  fft_state_e           state_q, state_d;
  logic [CW-1:0]        p_q, p_d;
  logic [LOG2_SIZE-1:0] outst_q, outst_d;
  logic                 err_q, err_d;
  logic                 cnt_clr;
  logic                 issue;
  logic [CW-1:0]        span;
  logic [CW-1:0]        grp;
  logic [CW-1:0]        twk;
  logic                 grp_wrap;
  logic                 grp_last;
  logic [CW-1:0]        n_idx;

  assign span  = CW'(SIZE) >> p_q;
  assign issue = (state_q == ISSUE) && bus.bf_ready;
  assign n_idx = grp * (span << 1) + twk;

  fft_idx_counter #(
    .SIZE      (SIZE),
    .LOG2_SIZE (LOG2_SIZE)
  ) u_idx (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .adv  (issue),
    .span (span),
    .g    (grp),
    .k    (twk),
    .wrap (grp_wrap),
    .last (grp_last)
  );

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    outst_d = outst_q;
    err_d   = err_q;
    cnt_clr = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ISSUE;
          p_d     = CW'(1);
          cnt_clr = 1'b1;
        end
      end
      ISSUE: begin
        if (issue && grp_wrap && grp_last) state_d = DRAIN;
      end
      DRAIN: begin
        // Pass barrier: the next pass reads results the current one writes back.
        if (outst_q == '0) begin
          if (p_q < CW'(LOG2_SIZE)) begin
            state_d = ISSUE;
            p_d     = p_q + CW'(1);
            cnt_clr = 1'b1;
          end else begin
            state_d = FINISH;
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (issue && !bus.bf_retire) begin
      outst_d = outst_q + LOG2_SIZE'(1);
    end else if (!issue && bus.bf_retire) begin
      if (outst_q != '0) outst_d = outst_q - LOG2_SIZE'(1);
      else               err_d   = 1'b1;
    end

    if (state_q == IDLE && bus.start) outst_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      outst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      outst_q <= outst_d;
      err_q   <= err_d;
    end
  end

  assign bus.bf_valid = (state_q == ISSUE);
  assign bus.busy     = (state_q == ISSUE) || (state_q == DRAIN);
  assign bus.done     = (state_q == FINISH);
  assign bus.err      = err_q;
  assign bus.p        = IDX_W'(p_q);
  assign bus.n        = IDX_W'(n_idx);
  assign bus.counter  = IDX_W'(twk);

endmodule

// File: tb/tb_fft_butterfly_seq.sv
// Scoreboard bench for the FFT butterfly sequencer (SIZE=8 main instance, SIZE=2 corner instance).
module tb_fft_butterfly_seq;

  typedef struct packed {
    logic        is_done;
    int unsigned p;
    int unsigned n;
    int unsigned c;
  } exp_t;

  logic clk;
  logic rst;

  fft_butterfly_seq_if ifc ();
  fft_butterfly_seq_if ifc2 ();

  fft_butterfly_seq #(.SIZE(8), .LOG2_SIZE(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  fft_butterfly_seq #(.SIZE(2), .LOG2_SIZE(1)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (ifc2)
  );

  int total = 0;
  int bad   = 0;

  exp_t sb[$];
  int   iss_cnt  = 0;
  int   ret_cnt  = 0;
  int   pend_ret = 0;
  int   done_cnt = 0;
  bit   ret_hold = 0;
  bit   spur_ret = 0;

  int exp_p [12] = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3};
  int exp_n [12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
  int exp_c [12] = '{0, 1, 2, 3, 0, 1, 0, 1, 0, 0, 0, 0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic push_transform();
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      e.is_done = 1'b0;
      e.p = exp_p[i];
      e.n = exp_n[i];
      e.c = exp_c[i];
      sb.push_back(e);
    end
    e.is_done = 1'b1;
    e.p = 0;
    e.n = 0;
    e.c = 0;
    sb.push_back(e);
  endtask

  // Called at posedge+1; start is sampled at the following edge.
  task automatic run_start();
    push_transform();
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0;
    bit got;
    d0  = done_cnt;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (done_cnt != d0) begin
        got = 1'b1;
        break;
      end
    end
    chk({name, "_done_seen"}, got, 1);
    chk({name, "_sb_empty"}, sb.size(), 0);
    chk({name, "_idle_busy"}, ifc.busy, 0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_n"},        ifc.n, 0);
    chk({name, "_p"},        ifc.p, 0);
    chk({name, "_counter"},  ifc.counter, 0);
    chk({name, "_bf_valid"}, ifc.bf_valid, 0);
    chk({name, "_busy"},     ifc.busy, 0);
    chk({name, "_done"},     ifc.done, 0);
    chk({name, "_err"},      ifc.err, 0);
    chk({name, "_outst"},    longint'(dut.outst_q), 0);
  endtask

  // Monitor: pops the scoreboard on every issue/done and tracks the outstanding count.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        iss_cnt = 0;
        ret_cnt = 0;
      end else begin
        if (ifc.busy) chk("outstanding", longint'(dut.outst_q), iss_cnt - ret_cnt);
        if (ifc.bf_valid && ifc.bf_ready) begin
          chk("sb_has_issue", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("issue_kind", 0, e.is_done);
            chk("issue_p", ifc.p, e.p);
            chk("issue_n", ifc.n, e.n);
            chk("issue_counter", ifc.counter, e.c);
          end
          iss_cnt++;
          pend_ret++;
        end
        if (ifc.done) begin
          done_cnt++;
          chk("sb_has_done", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("done_kind", 1, e.is_done);
          end
        end
        if (ifc.bf_retire && ret_cnt < iss_cnt) ret_cnt++;
      end
    end
  end

  // Downstream model: retires each butterfly the cycle after it issues unless held.
  initial begin : retire_agent
    bit fire;
    ifc.bf_retire = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        pend_ret      = 0;
        ifc.bf_retire = 1'b0;
      end else begin
        fire = (pend_ret > 0) && !ret_hold;
        if (fire) pend_ret--;
        ifc.bf_retire = fire || spur_ret;
        spur_ret      = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int base;
    int d0;
    bit hit;
    rst           = 1'b1;
    ifc.start     = 1'b0;
    ifc.bf_ready  = 1'b1;
    ifc2.start    = 1'b0;
    ifc2.bf_ready = 1'b1;
    ifc2.bf_retire = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Nominal run with a start pulse mid-transform that must be ignored.
    run_start();
    @(posedge clk); #1;
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    wait_done("nominal");

    // Backpressure: ready low for 3 cycles while (1,2,2) is presented.
    base = iss_cnt;
    run_start();
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (iss_cnt >= base + 2) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("bp_reached", hit, 1);
    ifc.bf_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid", ifc.bf_valid, 1);
      chk("bp_p", ifc.p, 1);
      chk("bp_n", ifc.n, 2);
      chk("bp_counter", ifc.counter, 2);
    end
    @(posedge clk); #1;
    ifc.bf_ready = 1'b1;
    wait_done("backpressure");

    // Pass barrier: retires held 5 cycles after the pass-1 issues.
    @(negedge clk);
    ret_hold = 1'b1;
    @(posedge clk); #1;
    base = iss_cnt;
    run_start();
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (iss_cnt >= base + 4) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("barrier_reached", hit, 1);
    repeat (5) begin
      @(negedge clk);
      chk("barrier_hold_valid", ifc.bf_valid, 0);
      chk("barrier_hold_busy", ifc.busy, 1);
      chk("barrier_hold_p", ifc.p, 1);
    end
    ret_hold = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("barrier_release_p", ifc.p, (i < 5) ? 2'd1 : 2'd2);
      chk("barrier_release_valid", ifc.bf_valid, (i < 5) ? 1'b0 : 1'b1);
    end
    wait_done("barrier");

    // Reset during pass 2: outputs clear, no done, then a clean restart.
    push_transform();
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (ifc.p == 2) begin
        hit = 1'b1;
        break;
      end
    end
    chk("midrst_reached_p2", hit, 1);
    d0  = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("midrst");
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt, d0);
    run_start();
    wait_done("restart");

    // Spurious retire while idle sets a sticky error.
    @(negedge clk);
    spur_ret = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("spurious_err", ifc.err, 1);
    chk("spurious_outst", longint'(dut.outst_q), 0);
    repeat (5) @(negedge clk);
    chk("spurious_err_sticky", ifc.err, 1);
    chk("spurious_idle", ifc.busy, 0);

    // SIZE=2: single butterfly then done.
    @(posedge clk); #1;
    ifc2.start = 1'b1;
    @(posedge clk); #1;
    ifc2.start = 1'b0;
    @(negedge clk);
    chk("s2_valid", ifc2.bf_valid, 1);
    chk("s2_p", ifc2.p, 1);
    chk("s2_n", ifc2.n, 0);
    chk("s2_counter", ifc2.counter, 0);
    chk("s2_busy", ifc2.busy, 1);
    @(posedge clk); #1;
    ifc2.bf_retire = 1'b1;
    @(negedge clk);
    chk("s2_drain_valid", ifc2.bf_valid, 0);
    chk("s2_drain_busy", ifc2.busy, 1);
    chk("s2_drain_done", ifc2.done, 0);
    @(posedge clk); #1;
    ifc2.bf_retire = 1'b0;
    @(negedge clk);
    chk("s2_pre_done", ifc2.done, 0);
    @(negedge clk);
    chk("s2_done", ifc2.done, 1);
    @(negedge clk);
    chk("s2_done_once", ifc2.done, 0);
    chk("s2_idle", ifc2.busy, 0);
    chk("s2_err", ifc2.err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_butterfly_seq.md
FFT_BUTTERFLY_SEQ -- requirements
Module: fft_butterfly_seq

Interface
REQ-001 The parameter SIZE SHALL default to 64 and set the FFT point count; it SHALL be a power of two, at least 2.
REQ-002 The parameter LOG2_SIZE SHALL default to 6 and equal log2(SIZE).
REQ-003 clk  input  1  the single clock; every register SHALL update on the rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 start  input  1  one-cycle request to begin a full transform.
REQ-006 bf_ready  input  1  the downstream butterfly stage accepts the current index set.
REQ-007 bf_retire  input  1  one-cycle pulse: the downstream stage has written back one butterfly.
REQ-008 n  output  32  first operand index (N1); zero-extended.
REQ-009 p  output  32  pass number, 1..LOG2_SIZE; zero-extended.
REQ-010 counter  output  32  twiddle index k within the group; zero-extended.
REQ-011 bf_valid  output  1  n, p and counter are valid for issue.
REQ-012 busy  output  1  a transform is in progress.
REQ-013 done  output  1  one-cycle pulse when the transform completes.
REQ-014 err  output  1  sticky flag set when a retire arrives with nothing outstanding.

Function
REQ-015 Per pass p, span SHALL equal SIZE>>p; the stage SHALL issue SIZE/2 butterflies, group-major then k-ascending: n = g*2*span + k, counter = k, for g in 0..(SIZE/(2*span))-1 and k in 0..span-1.
REQ-016 The downstream stage forms N2 = n + span and twiddle address = counter*(1<<p)/2; this block SHALL NOT output either value.
REQ-017 The FSM states SHALL be IDLE, ISSUE, DRAIN and FINISH.
REQ-018 IDLE -> ISSUE SHALL occur on start; on entry, p SHALL be 1, g and k SHALL be 0, and the outstanding count SHALL be 0.
REQ-019 In ISSUE, bf_valid SHALL be 1; an issue SHALL occur on the clk edge where bf_valid and bf_ready are both 1. The index set SHALL hold stable while bf_ready is 0.
REQ-020 After the last butterfly of a pass is issued, the state SHALL become DRAIN, with bf_valid 0.
REQ-021 DRAIN SHALL hold until the outstanding count is 0 (pass barrier).
- Exit to ISSUE with p+1 and g=k=0 when p < LOG2_SIZE.
- Exit to FINISH otherwise.
REQ-022 FINISH SHALL assert done for exactly one cycle, then return to IDLE.
REQ-023 busy SHALL be 1 in ISSUE and DRAIN, and 0 otherwise.
REQ-024 The outstanding count SHALL be LOG2_SIZE bits wide (range 0..SIZE/2).
- +1 on an issue.
- -1 on bf_retire.
- Unchanged when both occur in the same cycle.
REQ-025 bf_retire with the outstanding count at 0 (and no same-cycle issue) SHALL be ignored for counting and SHALL set err; only rst clears err.
REQ-026 start SHALL be ignored outside IDLE.
REQ-027 When start and rst are both high, rst SHALL win.
REQ-028 SIZE=2 SHALL give one pass, one butterfly: n=0, counter=0, p=1.
REQ-029 Issue-to-done latency with bf_ready held 1 and retire immediate SHALL be deterministic: one issue per cycle, plus the DRAIN wait per pass.

Reset
REQ-030 On rst, the state SHALL become IDLE and the outputs SHALL be: n=0, p=0, counter=0, bf_valid=0, busy=0, done=0, err=0; the outstanding count SHALL be 0.
REQ-031 rst mid-transform SHALL abandon the transform without asserting done; any later bf_retire SHALL be handled per REQ-025.

Structure
REQ-032 A shared package fft_pkg SHALL hold:
- the SIZE and LOG2_SIZE defaults;
- the state encoding type;
- the 32-bit index width constant.
The downstream butterfly stage and the twiddle-address logic SHALL also use fft_pkg.
REQ-033 One sub-module, fft_idx_counter, SHALL implement the nested g/k counters with span input and wrap/last outputs; all other logic SHALL be flat.

Verification
REQ-034 Nominal sequence: SIZE=8, start, bf_ready=1, retire one cycle after each issue. The (p,n,counter) sequence SHALL be:
- p=1: (1,0,0) (1,1,1) (1,2,2) (1,3,3)
- p=2: (2,0,0) (2,1,1) (2,4,0) (2,5,1)
- p=3: (3,0,0) (3,2,0) (3,4,0) (3,6,0)
- then a single done pulse.
REQ-035 Backpressure: bf_ready=0 for 3 cycles mid-pass. n, p and counter SHALL hold, bf_valid SHALL stay 1, and no index SHALL be skipped or duplicated.
REQ-036 Pass barrier: withhold retires for 5 cycles after the pass-1 issues. The state SHALL stay in DRAIN with bf_valid=0, and p=2 SHALL appear only after the 4th retire.
REQ-037 Boundaries:
- Simultaneous issue and retire SHALL keep the count unchanged.
- A spurious retire in IDLE SHALL set err=1 and leave it set.
- start while busy SHALL have no effect.
REQ-038 Reset mid-operation: rst during p=2. All outputs SHALL be 0 next cycle, with no done; a fresh start SHALL restart at (1,0,0).
REQ-039 SIZE=2: start SHALL produce a single issue (1,0,0), and done SHALL pulse after its retire.
